// File: rtl/vrom_pkg.sv
// Shared defaults and FSM encoding for the VROM burst reader.
package vrom_pkg;

    localparam int VROM_DEPTH  = 15486;
    localparam int VROM_DATA_W = 1100;

    function automatic int vrom_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int VROM_ADDR_W = vrom_addr_w(VROM_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } vrom_state_e;

endpackage

// File: rtl/vrom_rd_fifo.sv
// Synchronous FIFO buffering ROM read beats ahead of the output stream.
// The head entry is visible on o_rd_data whenever o_empty is low.
module vrom_rd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic [OCC_W-1:0] o_occupancy,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage needs no reset: nothing downstream looks at it while empty.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data   = r_mem[r_rd_ptr];
    assign o_occupancy = r_occ;
    assign o_full      = (r_occ == OCC_W'(DEPTH));
    assign o_empty     = (r_occ == '0);

endmodule

// File: rtl/vrom_reader.sv
// Burst reader: issues sequential reads to a 1-cycle-latency ROM and streams beats out.
// state    | meaning
// ST_IDLE  | waiting for start; validates range, pulses done (count=0) or err
// ST_ISSUE | issuing reads while FIFO occupancy + in-flight < FIFO_DEPTH
// ST_DRAIN | all reads issued; waiting for the m_last beat to be accepted
module vrom_reader
    import vrom_pkg::*;
#(
    parameter int ROM_DEPTH  = VROM_DEPTH,
    parameter int DATA_WIDTH = VROM_DATA_W,
    parameter int ADDR_WIDTH = vrom_addr_w(ROM_DEPTH),
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  arvalid,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  rready,
    input  logic                  rvalid,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   m_index,
    output logic                  m_last
);

    localparam int CW    = ADDR_WIDTH + 1;
    // One bit wider than count so no legal base/count pair can wrap.
    localparam int SW    = ADDR_WIDTH + 2;
    localparam int FW    = DATA_WIDTH + ADDR_WIDTH + 2;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [SW-1:0]    C_ROM_END = SW'(ROM_DEPTH);
    localparam logic [OCC_W:0]   C_CREDITS = (OCC_W + 1)'(FIFO_DEPTH);

    vrom_state_e           r_state;
    vrom_state_e           w_next;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_issued;
    logic [CW-1:0]         r_fl_idx;
    logic                  r_inflight;
    logic                  r_done;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_done_nxt;
    logic                  w_err_nxt;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_pop;
    logic                  w_fl_last;
    logic [SW-1:0]         w_end;
    logic [OCC_W:0]        w_credit;
    logic [OCC_W-1:0]      w_occ;
    logic                  w_full;
    logic                  w_empty;
    logic [FW-1:0]         w_wr_word;
    logic [FW-1:0]         w_head;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [CW-1:0]         w_head_idx;
    logic                  w_head_last;

    assign w_end        = SW'(base_addr) + SW'(count);
    assign w_credit     = (OCC_W + 1)'(w_occ) + (OCC_W + 1)'(r_inflight);
    assign w_issue      = (r_state == ST_ISSUE) && (w_credit < C_CREDITS);
    assign w_last_issue = w_issue && (r_issued == r_count - CW'(1));
    assign w_pop        = !w_empty && m_ready;

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        w_done_nxt = 1'b1;
                    end else if (w_end > C_ROM_END) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        w_next   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (w_last_issue) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_pop && w_head_last) begin
                    w_next     = ST_IDLE;
                    w_done_nxt = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_araddr   <= '0;
            r_count    <= '0;
            r_issued   <= '0;
            r_fl_idx   <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_inflight <= w_issue;
            if (w_accept) begin
                r_araddr <= base_addr;
                r_count  <= count;
                r_issued <= '0;
            end else if (w_issue) begin
                r_araddr <= r_araddr + ADDR_WIDTH'(1);
                r_issued <= r_issued + CW'(1);
            end
            if (w_issue) r_fl_idx <= r_issued;
        end
    end

    // ROM answers exactly one cycle after the issue, so the in-flight flag is the push.
    assign w_fl_last = (r_fl_idx == r_count - CW'(1));
    assign w_wr_word = {rdata, r_fl_idx, w_fl_last};

    vrom_rd_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH),
        .OCC_W (OCC_W)
    ) u_fifo (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_push      (r_inflight),
        .i_wr_data   (w_wr_word),
        .i_pop       (w_pop),
        .o_rd_data   (w_head),
        .o_occupancy (w_occ),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign {w_head_data, w_head_idx, w_head_last} = w_head;

    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;
    assign err     = r_err;
    assign arvalid = w_issue;
    assign rready  = w_issue;
    assign araddr  = r_araddr;
    assign m_valid = !w_empty;
    assign m_data  = w_empty ? '0 : w_head_data;
    assign m_index = w_empty ? '0 : w_head_idx;
    assign m_last  = !w_empty && w_head_last;

    a_rvalid_on_push: assert property (@(posedge clk) disable iff (!rst_n)
        r_inflight |-> rvalid);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        r_inflight |-> !w_full);

endmodule

// File: tb/tb_vrom_reader.sv
// Directed bench for vrom_reader against a 1-cycle ROM model holding word k = k.
module tb_vrom_reader;

    localparam int DW = 1100;
    localparam int AW = 14;
    localparam int CW = AW + 1;
    localparam int FD = 4;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] count;
    logic          busy;
    logic          done;
    logic          err;
    logic          arvalid;
    logic [AW-1:0] araddr;
    logic          rready;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] m_index;
    logic          m_last;

    vrom_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .arvalid   (arvalid),
        .araddr    (araddr),
        .rready    (rready),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_index   (m_index),
        .m_last    (m_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM model: word k = k, data one cycle after the accepted read, rvalid sticky.
    always @(posedge clk) begin
        if (arvalid && rready) begin
            rdata  <= DW'(araddr);
            rvalid <= 1'b1;
        end
    end

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int e0, first_ar, first_mv, done_cyc, err_cyc, last_cyc;
    int n_ar, n_beat, n_done, n_err, credit_bad, rr_bad, stall_bad;
    bit toggle;
    logic [3:0] pat = 4'b1001;
    bit hold;
    logic [31:0] h_data;
    logic [CW-1:0] h_idx;
    logic h_last;
    int q_data[$];
    int q_idx[$];
    int q_last[$];

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic mon_clear();
        first_ar = -1; first_mv = -1; done_cyc = -1; err_cyc = -1; last_cyc = -1;
        n_ar = 0; n_beat = 0; n_done = 0; n_err = 0;
        credit_bad = 0; rr_bad = 0; stall_bad = 0; hold = 1'b0;
        q_data.delete(); q_idx.delete(); q_last.delete();
    endtask

    // Sample the current cycle at the falling edge, then advance one clock.
    task automatic step();
        @(negedge clk);
        if (arvalid) begin
            if (first_ar < 0) first_ar = cyc;
            if (n_ar - n_beat >= FD) credit_bad++;
            n_ar++;
        end
        if (rready !== arvalid) rr_bad++;
        if (hold && (m_valid !== 1'b1 || m_data[31:0] !== h_data ||
                     m_index !== h_idx || m_last !== h_last)) stall_bad++;
        hold   = m_valid && !m_ready;
        h_data = m_data[31:0];
        h_idx  = m_index;
        h_last = m_last;
        if (m_valid && first_mv < 0) first_mv = cyc;
        if (m_valid && m_ready) begin
            q_data.push_back(int'(m_data[31:0]));
            q_idx.push_back(int'(m_index));
            q_last.push_back(int'(m_last));
            if (m_last) last_cyc = cyc;
            n_beat++;
        end
        if (done) begin n_done++; done_cyc = cyc; end
        if (err) begin n_err++; err_cyc = cyc; end
        @(posedge clk);
        #1;
        cyc++;
        m_ready = toggle ? pat[cyc[1:0]] : 1'b1;
    endtask

    task automatic pulse_start(input int base, input int cnt);
        mon_clear();
        base_addr = AW'(base);
        count     = CW'(cnt);
        start     = 1'b1;
        step();
        start = 1'b0;
        e0 = cyc - 1;
    endtask

    task automatic run_burst(input int base, input int cnt, input bit tog, input bit poke);
        int n;
        toggle = tog;
        pulse_start(base, cnt);
        n = 0;
        while (n_done == 0 && n < 300) begin
            start = 1'b0;
            if (poke && n == 2) begin start = 1'b1; base_addr = AW'(200); count = '0; end
            if (poke && n == 4) begin start = 1'b1; base_addr = AW'(300); count = CW'(3); end
            step();
            n++;
        end
        start = 1'b0;
        repeat (3) step();
        toggle = 1'b0;
        chk_val("burst_done_count", n_done, 1);
        chk_val("done_after_last", done_cyc, last_cyc + 1);
        chk_val("busy_after", busy, 0);
        chk_val("no_err", n_err, 0);
        chk_val("rready_eq_arvalid", rr_bad, 0);
        chk_val("credit_rule", credit_bad, 0);
        chk_val("stall_hold", stall_bad, 0);
    endtask

    task automatic check_beats(input int base, input int cnt);
        chk_val("n_beats", q_data.size(), cnt);
        for (int i = 0; i < q_data.size() && i < cnt; i++) begin
            chk_val("beat_data", q_data[i], base + i);
            chk_val("beat_index", q_idx[i], i);
            chk_val("beat_last", q_last[i], (i == cnt - 1) ? 1 : 0);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk_val({tag, "_busy"}, busy, 0);
        chk_val({tag, "_done"}, done, 0);
        chk_val({tag, "_err"}, err, 0);
        chk_val({tag, "_arvalid"}, arvalid, 0);
        chk_val({tag, "_rready"}, rready, 0);
        chk_val({tag, "_m_valid"}, m_valid, 0);
        chk_val({tag, "_m_last"}, m_last, 0);
        chk_val({tag, "_araddr"}, araddr, 0);
        chk_val({tag, "_m_index"}, m_index, 0);
        chk_val({tag, "_m_data"}, |m_data, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0;
        m_ready = 1'b1; toggle = 1'b0;
        mon_clear();
        repeat (3) step();
        chk_quiet("reset");
        rst_n = 1'b1;
        step();

        // base 5, count 4, m_ready held high
        run_burst(5, 4, 1'b0, 1'b0);
        check_beats(5, 4);
        chk_val("first_arvalid", first_ar, e0 + 1);
        chk_val("first_m_valid", first_mv, e0 + 3);
        chk_val("one_beat_per_cycle", last_cyc, e0 + 6);

        // base 0, count 8, m_ready pattern 1,0,0,1
        run_burst(0, 8, 1'b1, 1'b0);
        check_beats(0, 8);

        // zero-length burst
        pulse_start(7, 0);
        repeat (4) step();
        chk_val("zero_done_count", n_done, 1);
        chk_val("zero_done_cycle", done_cyc, e0 + 1);
        chk_val("zero_no_arvalid", n_ar, 0);
        chk_val("zero_busy", busy, 0);

        // range overflow by one word
        pulse_start(15480, 7);
        repeat (4) step();
        chk_val("range_err_count", n_err, 1);
        chk_val("range_err_cycle", err_cyc, e0 + 1);
        chk_val("range_no_arvalid", n_ar, 0);
        chk_val("range_no_done", n_done, 0);

        // range exactly reaching the last ROM word
        run_burst(15480, 6, 1'b0, 1'b0);
        check_beats(15480, 6);

        // start pulses while busy must be ignored
        run_burst(100, 10, 1'b0, 1'b1);
        check_beats(100, 10);

        // reset after beat 2 of a 10-beat burst
        pulse_start(20, 10);
        n = 0;
        while (n_beat < 3 && n < 50) begin step(); n++; end
        chk_val("rst_mid_reached", n_beat, 3);
        rst_n = 1'b0;
        step();
        chk_quiet("rst_mid");
        rst_n = 1'b1;
        mon_clear();
        repeat (6) step();
        chk_val("rst_mid_no_done", n_done, 0);
        chk_val("rst_mid_no_beats", n_beat, 0);

        run_burst(40, 5, 1'b0, 1'b0);
        check_beats(40, 5);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
